// File: rtl/dmem_router_pkg.sv
// Shared constants for the data-memory interconnect: slave base nibbles,
// tracker counter width and the slave-index width helper.
package dmem_router_pkg;

    localparam logic [3:0] MEM_BASE   = 4'h0;
    localparam logic [3:0] CLINT_BASE = 4'h2;

    // Outstanding-read counter width; covers MAX_OUTST up to 15.
    localparam int CNT_W = 4;

    // Width of a slave index; never collapses to zero for a single slave.
    function automatic int slv_idx_w(input int nslv);
        return (nslv > 1) ? $clog2(nslv) : 1;
    endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Address-nibble decoder: lowest-index slave whose base nibble matches wins,
// otherwise the default slave. Produces both an index and a one-hot select.
module dmem_addr_decode
    import dmem_router_pkg::*;
#(
    parameter int                NSLV        = 2,
    parameter logic [4*NSLV-1:0] SLV_BASE    = {CLINT_BASE, MEM_BASE},
    parameter int                DEFAULT_SLV = 0,
    localparam int               IDX_W       = slv_idx_w(NSLV)
) (
    input  logic [3:0]       i_nib,
    output logic [IDX_W-1:0] o_sel_idx,
    output logic [NSLV-1:0]  o_sel_oh
);

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        o_sel_idx = IDX_W'(DEFAULT_SLV);
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (i_nib == SLV_BASE[4*i +: 4]) begin
                o_sel_idx = IDX_W'(i);
            end
        end
    end

    // Expand the selected index into a one-hot vector.
    always_comb begin
        o_sel_oh = '0;
        for (int i = 0; i < NSLV; i++) begin
            o_sel_oh[i] = (o_sel_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dmem_router.sv
// Core dmem port to NSLV slaves. Writes are routed combinationally; reads are
// tracked (count + owning slave) so each response is steered back from the
// slave that owns the outstanding reads. Reads to a different slave wait until
// the pipe drains, which keeps responses in order without a reorder buffer.
module dmem_router
    import dmem_router_pkg::*;
#(
    parameter int                NSLV        = 2,
    parameter logic [4*NSLV-1:0] SLV_BASE    = {CLINT_BASE, MEM_BASE},
    parameter int                DEFAULT_SLV = 0,
    parameter int                MAX_OUTST   = 2,
    localparam int               IDX_W       = slv_idx_w(NSLV)
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 m_wready,
    output logic                 m_wvalid,
    input  logic [31:0]          m_waddr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    input  logic                 m_rready,
    output logic                 m_rvalid,
    input  logic [31:0]          m_raddr,
    output logic                 m_rresp,
    output logic [31:0]          m_rdata,
    output logic [NSLV-1:0]      s_wready,
    input  logic [NSLV-1:0]      s_wvalid,
    output logic [31:0]          s_waddr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    output logic [NSLV-1:0]      s_rready,
    input  logic [NSLV-1:0]      s_rvalid,
    output logic [31:0]          s_raddr,
    input  logic [NSLV-1:0]      s_rresp,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic                 busy,
    output logic                 resp_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic [1:0]       r_rst_sync;
    logic             w_rst_b;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_owner;
    logic             r_resp_err;

    logic [IDX_W-1:0] w_wsel_idx;
    logic [NSLV-1:0]  w_wsel_oh;
    logic [IDX_W-1:0] w_rsel_idx;
    logic [NSLV-1:0]  w_rsel_oh;
    logic [NSLV-1:0]  w_owner_oh;
    logic [31:0]      w_owner_data;
    logic             w_cnt_nz;
    logic             w_issue_ok;
    logic             w_rd_acc;
    logic             w_fwd;
    logic             w_stray;

    dmem_addr_decode #(
        .NSLV        (NSLV),
        .SLV_BASE    (SLV_BASE),
        .DEFAULT_SLV (DEFAULT_SLV)
    ) u_wdec (
        .i_nib     (m_waddr[31:28]),
        .o_sel_idx (w_wsel_idx),
        .o_sel_oh  (w_wsel_oh)
    );

    dmem_addr_decode #(
        .NSLV        (NSLV),
        .SLV_BASE    (SLV_BASE),
        .DEFAULT_SLV (DEFAULT_SLV)
    ) u_rdec (
        .i_nib     (m_raddr[31:28]),
        .o_sel_idx (w_rsel_idx),
        .o_sel_oh  (w_rsel_oh)
    );

    // Reset asserts immediately, releases two clk edges later.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_b = r_rst_sync[1];

    // Broadcast buses simply mirror the core request.
    assign s_waddr = m_waddr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;
    assign s_raddr = m_raddr;

    // Handshakes are held off until reset has fully released.
    assign s_wready = w_wsel_oh & {NSLV{w_rst_b & m_wready}};
    assign m_wvalid = w_rst_b & s_wvalid[w_wsel_idx];

    assign w_cnt_nz   = (r_cnt != '0);
    assign w_issue_ok = w_rst_b && (r_cnt < MAX_CNT) &&
                        (!w_cnt_nz || (w_rsel_idx == r_owner));
    assign s_rready   = w_rsel_oh & {NSLV{w_issue_ok & m_rready}};
    assign m_rvalid   = w_issue_ok & (|(s_rvalid & w_rsel_oh));
    assign w_rd_acc   = m_rready & m_rvalid;

    // One-hot owner and its read-data lane.
    always_comb begin
        w_owner_oh   = '0;
        w_owner_data = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_owner_oh[i] = (r_owner == IDX_W'(i));
            if (w_owner_oh[i]) begin
                w_owner_data = s_rdata[32*i +: 32];
            end
        end
    end

    // Only the owner's response is forwarded, and only with reads in flight;
    // anything else is a stray that is dropped and flagged.
    assign w_fwd   = w_cnt_nz & (|(s_rresp & w_owner_oh));
    assign w_stray = (|(s_rresp & ~w_owner_oh)) | (~w_cnt_nz & (|s_rresp));
    assign m_rresp = w_fwd;
    assign m_rdata = w_cnt_nz ? w_owner_data : 32'h0;
    assign busy     = w_cnt_nz;
    assign resp_err = r_resp_err;

    // Outstanding-read tracker: count, owning slave and sticky stray flag.
    always_ff @(posedge clk or negedge w_rst_b) begin
        if (!w_rst_b) begin
            r_cnt      <= '0;
            r_owner    <= IDX_W'(DEFAULT_SLV);
            r_resp_err <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_owner <= w_rsel_idx;
            end
            case ({w_rd_acc, w_fwd})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_stray) begin
                r_resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_router.sv
// Bench for dmem_router: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model of the
// outstanding reads.
module tb_dmem_router;

    localparam int NSLV = 2;
    localparam int MAX  = 2;
    localparam int DEF  = 0;
    localparam logic [3:0] BASES [NSLV] = '{4'h0, 4'h2};

    logic              clk = 1'b0;
    logic              resetb = 1'b0;
    logic              m_wready, m_wvalid, m_rready, m_rvalid, m_rresp;
    logic [31:0]       m_waddr, m_wdata, m_raddr, m_rdata;
    logic [3:0]        m_wstrb, s_wstrb;
    logic [NSLV-1:0]   s_wready, s_wvalid, s_rready, s_rvalid, s_rresp;
    logic [31:0]       s_waddr, s_wdata, s_raddr;
    logic [NSLV*32-1:0] s_rdata;
    logic              busy, resp_err;

    int n_cmp = 0;
    int n_fail = 0;

    int q[$];
    bit err_m;
    int slv_pend [NSLV];

    always #5 clk = ~clk;

    dmem_router #(
        .NSLV        (NSLV),
        .SLV_BASE    ({4'h2, 4'h0}),
        .DEFAULT_SLV (DEF),
        .MAX_OUTST   (MAX)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .m_wready (m_wready),
        .m_wvalid (m_wvalid),
        .m_waddr  (m_waddr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rready (m_rready),
        .m_rvalid (m_rvalid),
        .m_raddr  (m_raddr),
        .m_rresp  (m_rresp),
        .m_rdata  (m_rdata),
        .s_wready (s_wready),
        .s_wvalid (s_wvalid),
        .s_waddr  (s_waddr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rready (s_rready),
        .s_rvalid (s_rvalid),
        .s_raddr  (s_raddr),
        .s_rresp  (s_rresp),
        .s_rdata  (s_rdata),
        .busy     (busy),
        .resp_err (resp_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [3:0] nib);
        for (int i = 0; i < NSLV; i++) begin
            if (nib == BASES[i]) return i;
        end
        return DEF;
    endfunction

    // Reference model and per-cycle compare, evaluated mid-cycle.
    always @(negedge clk) begin
        int wsel, rsel, n, own;
        logic allow, e_mwv, e_mrv, e_rr;
        logic [NSLV-1:0] e_swr, e_srr;
        logic [31:0] e_rd;
        bit stray;
        chk("bc_waddr", 64'(s_waddr), 64'(m_waddr));
        chk("bc_wdata", 64'(s_wdata), 64'(m_wdata));
        chk("bc_wstrb", 64'(s_wstrb), 64'(m_wstrb));
        chk("bc_raddr", 64'(s_raddr), 64'(m_raddr));
        if (!resetb) begin
            q.delete();
            err_m = 1'b0;
            for (int j = 0; j < NSLV; j++) slv_pend[j] = 0;
            chk("rst_s_wready", 64'(s_wready), 64'h0);
            chk("rst_m_wvalid", 64'(m_wvalid), 64'h0);
            chk("rst_s_rready", 64'(s_rready), 64'h0);
            chk("rst_m_rvalid", 64'(m_rvalid), 64'h0);
            chk("rst_m_rresp",  64'(m_rresp),  64'h0);
            chk("rst_m_rdata",  64'(m_rdata),  64'h0);
            chk("rst_busy",     64'(busy),     64'h0);
            chk("rst_resp_err", 64'(resp_err), 64'h0);
        end else begin
            wsel = dec(m_waddr[31:28]);
            rsel = dec(m_raddr[31:28]);
            n = q.size();
            own = (n > 0) ? q[0] : -1;
            e_swr = '0;
            if (m_wready) e_swr[wsel] = 1'b1;
            e_mwv = s_wvalid[wsel];
            allow = (n < MAX) && (n == 0 || own == rsel);
            e_srr = '0;
            if (allow && m_rready) e_srr[rsel] = 1'b1;
            e_mrv = allow && s_rvalid[rsel];
            e_rr = 1'b0;
            e_rd = 32'h0;
            if (n > 0) begin
                e_rr = s_rresp[own];
                e_rd = s_rdata[32*own +: 32];
            end
            chk("s_wready", 64'(s_wready), 64'(e_swr));
            chk("m_wvalid", 64'(m_wvalid), 64'(e_mwv));
            chk("s_rready", 64'(s_rready), 64'(e_srr));
            chk("m_rvalid", 64'(m_rvalid), 64'(e_mrv));
            chk("m_rresp",  64'(m_rresp),  64'(e_rr));
            chk("m_rdata",  64'(m_rdata),  64'(e_rd));
            chk("busy",     64'(busy),     64'(n > 0));
            chk("resp_err", 64'(resp_err), 64'(err_m));
            stray = 1'b0;
            for (int j = 0; j < NSLV; j++) begin
                if (s_rresp[j] && (n == 0 || j != own)) stray = 1'b1;
                if (s_rresp[j] && slv_pend[j] > 0) slv_pend[j]--;
                if (e_srr[j] && s_rvalid[j]) slv_pend[j]++;
            end
            if (stray) err_m = 1'b1;
            if (e_rr) void'(q.pop_front());
            if (m_rready && e_mrv) q.push_back(rsel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_wready = 0; m_waddr = 0; m_wdata = 0; m_wstrb = 0;
        m_rready = 0; m_raddr = 0;
        s_wvalid = 0; s_rvalid = 0; s_rresp = 0; s_rdata = 0;
    endtask

    // Reset with every handshake input active, then release on idle inputs.
    task automatic do_reset();
        tick();
        resetb = 0;
        m_wready = 1; m_rready = 1;
        s_wvalid = '1; s_rvalid = '1; s_rresp = '1;
        s_rdata = {$urandom, $urandom};
        tick();
        tick();
        idle();
        resetb = 1;
        repeat (3) tick();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [3:0] nib;
        case ($urandom_range(0, 3))
            0: nib = 4'h0;
            1: nib = 4'h2;
            2: nib = 4'h7;
            default: nib = 4'($urandom_range(0, 15));
        endcase
        return {nib, 28'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        resetb = 0;
        do_reset();
        chk("lit_rst_busy", 64'(busy), 64'h0);
        chk("lit_rst_err",  64'(resp_err), 64'h0);

        // Write routed to slave 1 and to the default slave.
        tick(); m_wready = 1; m_waddr = 32'h2000_4000; m_wdata = 32'h55AA_0001; m_wstrb = 4'hF; s_wvalid = 2'b10;
        #2; chk("lit_w1_sready", 64'(s_wready), 64'h2); chk("lit_w1_mvalid", 64'(m_wvalid), 64'h1);
        tick(); m_waddr = 32'h7000_0000; s_wvalid = 2'b01;
        #2; chk("lit_w2_sready", 64'(s_wready), 64'h1); chk("lit_w2_mvalid", 64'(m_wvalid), 64'h1);

        // Single read, response next cycle.
        tick(); idle(); m_raddr = 32'h0000_0010; m_rready = 1; s_rvalid = 2'b01;
        #2; chk("lit_r1_mvalid", 64'(m_rvalid), 64'h1); chk("lit_r1_sready", 64'(s_rready), 64'h1);
        tick(); m_rready = 0; s_rvalid = 0; s_rresp = 2'b01; s_rdata = {32'h0, 32'hDEAD_BEEF};
        #2; chk("lit_r1_rresp", 64'(m_rresp), 64'h1); chk("lit_r1_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        chk("lit_r1_busy1", 64'(busy), 64'h1);
        tick(); idle();
        #2; chk("lit_r1_busy0", 64'(busy), 64'h0);

        // Fill to MAX_OUTST, third request stalls until a response lands.
        tick(); m_raddr = 32'h0000_0100; m_rready = 1; s_rvalid = 2'b01;
        tick();
        tick();
        #2; chk("lit_max_mvalid", 64'(m_rvalid), 64'h0); chk("lit_max_sready", 64'(s_rready), 64'h0);
        tick(); s_rresp = 2'b01; s_rdata = {32'h0, 32'h0000_0A01};
        #2; chk("lit_max_stall2", 64'(m_rvalid), 64'h0); chk("lit_max_rresp", 64'(m_rresp), 64'h1);
        tick(); s_rresp = 0;
        #2; chk("lit_max_issue", 64'(m_rvalid), 64'h1);
        tick(); m_rready = 0; s_rresp = 2'b01;
        tick();
        tick(); idle();
        #2; chk("lit_max_drain", 64'(busy), 64'h0);

        // Read to another slave waits for the pipe to drain.
        tick(); m_raddr = 32'h0000_0020; m_rready = 1; s_rvalid = 2'b11;
        tick(); m_raddr = 32'h2000_0000;
        #2; chk("lit_own_stall", 64'(m_rvalid), 64'h0); chk("lit_own_sready0", 64'(s_rready), 64'h0);
        tick(); s_rresp = 2'b01; s_rdata = {32'h0, 32'h0000_0B01};
        #2; chk("lit_own_stall2", 64'(m_rvalid), 64'h0);
        tick(); s_rresp = 0;
        #2; chk("lit_own_issue", 64'(m_rvalid), 64'h1); chk("lit_own_sready", 64'(s_rready), 64'h2);
        tick(); m_rready = 0; s_rvalid = 0; s_rresp = 2'b10; s_rdata = {32'h1234_5678, 32'h0};
        #2; chk("lit_own_rresp", 64'(m_rresp), 64'h1); chk("lit_own_rdata", 64'(m_rdata), 64'h1234_5678);
        tick(); idle();

        // Accept and response in the same cycle.
        tick(); m_raddr = 32'h0000_0030; m_rready = 1; s_rvalid = 2'b01;
        tick(); s_rresp = 2'b01; s_rdata = {32'h0, 32'hCAFE_0001};
        #2; chk("lit_sim_mvalid", 64'(m_rvalid), 64'h1); chk("lit_sim_rdata", 64'(m_rdata), 64'hCAFE_0001);
        tick(); m_rready = 0; s_rresp = 0;
        #2; chk("lit_sim_busy", 64'(busy), 64'h1);
        tick(); s_rresp = 2'b01;
        tick(); idle();
        #2; chk("lit_sim_busy0", 64'(busy), 64'h0);

        // Stray response while idle.
        tick(); s_rresp = 2'b10; s_rdata = {32'hBAD0_0000, 32'h0};
        #2; chk("lit_str_rresp", 64'(m_rresp), 64'h0);
        tick(); idle();
        #2; chk("lit_str_err", 64'(resp_err), 64'h1);
        do_reset();
        chk("lit_str_errclr", 64'(resp_err), 64'h0);

        // Stray from the non-owner while a read is outstanding.
        tick(); m_raddr = 32'h0000_0040; m_rready = 1; s_rvalid = 2'b01;
        tick(); m_rready = 0; s_rvalid = 0; s_rresp = 2'b10;
        #2; chk("lit_nown_rresp", 64'(m_rresp), 64'h0);
        tick(); s_rresp = 0;
        #2; chk("lit_nown_busy", 64'(busy), 64'h1); chk("lit_nown_err", 64'(resp_err), 64'h1);
        tick(); s_rresp = 2'b01;
        #2; chk("lit_nown_fwd", 64'(m_rresp), 64'h1);
        tick(); idle();

        // Reset in the middle of a read.
        tick(); m_raddr = 32'h0000_0050; m_rready = 1; s_rvalid = 2'b01;
        tick(); m_rready = 0; s_rvalid = 0; s_rresp = 2'b01; resetb = 0;
        #2; chk("lit_mid_busy", 64'(busy), 64'h0); chk("lit_mid_err", 64'(resp_err), 64'h0);
        chk("lit_mid_rresp", 64'(m_rresp), 64'h0);
        tick();
        idle();
        resetb = 1;
        repeat (3) tick();

        // Randomized traffic with legal slaves and occasional strays/resets.
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 500; c++) begin
                tick();
                m_wready = 1'($urandom_range(0, 1));
                m_waddr  = pick_addr();
                m_wdata  = $urandom;
                m_wstrb  = 4'($urandom);
                s_wvalid = NSLV'($urandom);
                m_rready = ($urandom_range(0, 9) < 7);
                m_raddr  = pick_addr();
                s_rvalid = NSLV'($urandom);
                s_rdata  = {$urandom, $urandom};
                s_rresp  = '0;
                for (int j = 0; j < NSLV; j++) begin
                    if (slv_pend[j] > 0 && $urandom_range(0, 2) == 0) s_rresp[j] = 1'b1;
                end
                if ($urandom_range(0, 63) == 0) s_rresp[$urandom_range(0, NSLV-1)] = 1'b1;
                if ($urandom_range(0, 249) == 0) do_reset();
            end
            do_reset();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_router.md
Name: dmem_router

Overview:
- Parametrised data-memory interconnect between the riscv core dmem port and NSLV slaves (CLINT, data RAM, peripherals).
- Each slave is selected by address bits [31:28] matched against a per-slave base nibble. Unmatched addresses go to slave DEFAULT_SLV.
- Tracks outstanding reads (up to MAX_OUTST) and routes each read response from the owning slave back to the core, replacing the one-cycle delayed data-select scheme.
- Write path is combinational routing. Read-response ownership, ordering and error detection are sequential.

Parameters:
- NSLV, 2, number of slaves (1..8).
- SLV_BASE, {4'h2,4'h0}, packed NSLV x 4-bit base nibbles; slave i owns addr[31:28]==SLV_BASE[4i+3:4i].
- DEFAULT_SLV, 0, slave index used when no base matches.
- MAX_OUTST, 2, maximum outstanding reads (1..15).

Ports:
- clk  in  1  clock
- resetb  in  1  async active-low reset
- m_wready  in  1  core write request
- m_wvalid  out  1  write accepted
- m_waddr  in  32  write address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte strobes
- m_rready  in  1  core read request
- m_rvalid  out  1  read request accepted
- m_raddr  in  32  read address
- m_rresp  out  1  read data valid
- m_rdata  out  32  read data
- s_wready  out  NSLV  per-slave write request
- s_wvalid  in  NSLV  per-slave write accept
- s_waddr/s_wdata/s_wstrb  out  32/32/4  broadcast copies of m_*
- s_rready  out  NSLV  per-slave read request
- s_rvalid  in  NSLV  per-slave read accept
- s_raddr  out  32  broadcast read address
- s_rresp  in  NSLV  per-slave read data valid
- s_rdata  in  NSLV*32  packed per-slave read data
- busy  out  1  outstanding read count != 0
- resp_err  out  1  sticky: stray response seen

Behaviour:

Reset:
- Async assert, sync release.
- Outstanding count=0, owner=DEFAULT_SLV, resp_err=0.
- All outputs 0 except broadcast buses, which follow the m_* inputs.

Decode:
- wsel / rsel = lowest-index slave whose base matches, else DEFAULT_SLV.
- Decode is purely combinational on m_waddr / m_raddr.

Write path (zero latency):
- s_wready[wsel] = m_wready; all other bits 0.
- m_wvalid = s_wvalid[wsel].
- Transfer completes when m_wready && m_wvalid.
- Writes are independent of read tracking.

Read issue:
- Issue is allowed when cnt<MAX_OUTST and (cnt==0 or rsel==owner).
- Same-owner rule: responses are in order per slave, so no reorder buffer is needed.
- When allowed: s_rready[rsel] = m_rready and m_rvalid = s_rvalid[rsel].
- When not allowed: s_rready=0 and m_rvalid=0; the core stalls holding its request.
- On an accepted read (m_rready && m_rvalid): owner<=rsel; cnt increments.

Read response:
- m_rresp = s_rresp[owner] && cnt!=0.
- m_rdata = s_rdata[owner] while cnt!=0, else 0.
- Each forwarded response decrements cnt.

Simultaneous accept and response in one cycle:
- cnt unchanged.
- owner still loads rsel, which is legal because rsel==owner whenever cnt!=0.
- A same-cycle response to a request issued while cnt==0 is not forwarded: minimum read latency is 1 cycle.

Errors:
- s_rresp[j] with j!=owner, or any s_rresp while cnt==0, sets resp_err.
- That response is dropped and cnt is unchanged.
- resp_err clears only on reset.

Other rules:
- cnt saturation is guarded by the issue rule; cnt never exceeds MAX_OUTST.
- Reset mid-transaction discards all outstanding state. Slaves must be reset by the same resetb.
- busy = (cnt!=0), registered-state derived.

Decomposition:
- Shared package/header (opcode.vh style): CLINT_BASE, MEM_BASE nibble constants, and a SLV_IDX_W = clog2(NSLV) width helper.
- One sub-module, dmem_addr_decode: combinational address → one-hot/index with default. It is instantiated twice (read and write paths).
- The tracker (cnt/owner/resp_err) stays in dmem_router.

Test Plan:
- NSLV=2, SLV_BASE={2,0}: write to 0x2000_4000 with s_wvalid=2'b10 → s_wready=2'b10, m_wvalid=1 in the same cycle. Write to 0x7000_0000 → default slave 0 selected.
- Read 0x0000_0010 accepted; slave 0 returns rresp next cycle with 0xDEADBEEF → m_rresp=1, m_rdata=0xDEADBEEF, busy 1→0.
- MAX_OUTST=2: two back-to-back reads to slave 0 with slave responses withheld → third request sees m_rvalid=0 and s_rready=0 until the first response arrives.
- Outstanding read to slave 0, core requests 0x2000_0000 → stalled (m_rvalid=0) until cnt=0, then issued to slave 1 with owner=1.
- Accept and response in the same cycle with cnt=1 → cnt stays 1, data forwarded.
- s_rresp[1] pulse while owner=0 or cnt=0 → resp_err=1, m_rresp=0. Assert resetb mid-read → cnt=0, busy=0, resp_err=0.
